// File: rtl/pipelined_adder_pkg.sv
// Shared operand types for the pipelined adder and its upstream feeder.
package pipelined_adder_pkg;
  localparam int ADDER_WIDTH = 26;

  typedef logic [ADDER_WIDTH-1:0] operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } operand_pair_t;
endpackage

// File: rtl/adder_operand_fifo.sv
// Synchronous FIFO of operand pairs; storage is unreset, only pointers and occupancy clear.
module adder_operand_fifo
  import pipelined_adder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clock0,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  operand_pair_t                wdata,
  output operand_pair_t                rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  operand_pair_t  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clock0) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clock0) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pipelined_adder_feeder.sv
// Operand stage for pipelined_adder: buffers pairs, issues one per cycle and
// tracks each issue through the adder latency to mark valid sums.
module pipelined_adder_feeder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH       = ADDER_WIDTH,
  parameter int DEPTH       = 16,
  parameter int ADD_LATENCY = 2
) (
  input  logic                        clock0,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_op_a,
  input  logic [WIDTH-1:0]            in_op_b,
  input  logic                        hold,
  output logic [WIDTH-1:0]            op_a,
  output logic [WIDTH-1:0]            op_b,
  output logic                        issue,
  output logic                        result_valid,
  output logic [$clog2(DEPTH+1)-1:0]  count
);
  operand_pair_t           w_wdata;
  operand_pair_t           w_rdata;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [WIDTH-1:0]        r_op_a;
  logic [WIDTH-1:0]        r_op_b;
  logic                    r_issue;
  logic [ADD_LATENCY-1:0]  r_dly;

  assign w_wdata  = '{a: operand_t'(in_op_a), b: operand_t'(in_op_b)};
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_pop    = !w_empty && !hold;

  adder_operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock0 (clock0),
    .reset  (reset),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (w_wdata),
    .rdata  (w_rdata),
    .full   (w_full),
    .empty  (w_empty),
    .count  (count)
  );

  // The delay line is cleared with the issue register so no stale result survives a reset.
  always_ff @(posedge clock0) begin
    if (!reset) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_issue <= 1'b0;
      r_dly   <= '0;
    end else begin
      r_issue <= w_pop;
      r_dly   <= (r_dly << 1) | ADD_LATENCY'(r_issue);
      if (w_pop) begin
        r_op_a <= WIDTH'(w_rdata.a);
        r_op_b <= WIDTH'(w_rdata.b);
      end
    end
  end

  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign issue        = r_issue;
  assign result_valid = r_dly[ADD_LATENCY-1];
endmodule

// File: doc/pipelined_adder_feeder.md
Name: pipelined_adder_feeder

Overview:
- Upstream operand stage for pipelined_adder.
- Accepts operand pairs over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one pair per cycle onto registered op_a/op_b outputs that drive the adder directly.
- Carries an issue token down a delay line of ADD_LATENCY stages, so result_valid marks exactly the cycles in which the adder's out holds a real sum.

Parameters:
- WIDTH, 26: operand width; matches the adder operand width.
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.
- ADD_LATENCY, 2: clock cycles from op_a/op_b registered to the adder's out valid; must be at least 1.

Ports:
- clock0  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset. 0 sampled at a rising edge resets the block.
- in_valid  input  1  upstream has an operand pair.
- in_ready  output  1  FIFO can accept a pair this cycle.
- in_op_a  input  WIDTH  operand A.
- in_op_b  input  WIDTH  operand B.
- hold  input  1  when 1, suppresses issue; the FIFO keeps its contents.
- op_a  output  WIDTH  registered operand A to the adder.
- op_b  output  WIDTH  registered operand B to the adder.
- issue  output  1  1 in a cycle where op_a/op_b carry a newly popped pair.
- result_valid  output  1  issue delayed by ADD_LATENCY cycles; aligned with the adder's out.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FIFO is flushed: pointers = 0, count = 0.
  - op_a = 0, op_b = 0, issue = 0.
  - Every delay-line stage = 0, so result_valid = 0.
  - in_ready = 1 from the first cycle after reset is released.
  - A mid-operation reset discards all buffered and in-flight pairs. No result_valid pulse from a pre-reset issue ever appears.
- Push:
  - in_ready = (count != DEPTH); combinational from registered state only.
  - A pair is written at the tail when in_valid && in_ready.
  - in_valid while full is ignored, with no overwrite and no error flag.
- Pop/issue:
  - A pair is popped when count != 0 && !hold.
  - The head pair is registered into op_a/op_b, and issue = 1 on the next cycle.
  - Otherwise issue = 0 and op_a/op_b hold their previous values.
- Latency:
  - A pair accepted at edge N into an empty FIFO appears on op_a/op_b at edge N+1, with issue = 1 that cycle, provided hold == 0.
  - The matching result_valid rises ADD_LATENCY edges later.
  - Pairs are issued in strict FIFO order.
- Simultaneous push and pop:
  - Allowed whenever count is not 0 and not DEPTH; count is unchanged.
  - When full, in_ready = 0, so a pop that cycle frees a slot only for the next cycle. There is no full-bypass.
  - When empty, a push does not bypass into the issue register in the same cycle.
- Pointers: log2(DEPTH) bits wide; wrap naturally from DEPTH-1 to 0.
- count: exact occupancy, 0..DEPTH inclusive.
- Throughput: one pair per cycle sustained with in_valid = 1 and hold = 0.
- hold:
  - Does not affect accept; the FIFO fills while held.
  - Pairs already in the delay line still produce result_valid.
- No arithmetic is performed in this block; operands pass through bit-exact.

Decomposition:
- Shared package pipelined_adder_pkg:
  - localparam ADDER_WIDTH = 26.
  - typedef operand_t as logic [ADDER_WIDTH-1:0].
  - typedef struct packed operand_pair_t with fields a and b.
- One sub-module, adder_operand_fifo:
  - Synchronous FIFO of operand_pair_t, parameterised by DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Same clock0 and active-low synchronous reset.
- The top level holds the issue register and the ADD_LATENCY-deep shift register for result_valid.

Test Plan:
1. Single pair after reset (hold = 0, DEPTH = 16, ADD_LATENCY = 2): reset low 10 cycles, then push a = 26'h0000005, b = 26'h0000003 at edge N. Required: op_a = 5, op_b = 3, issue = 1 at edge N+1; result_valid = 1 only at edge N+3; count returns to 0.
2. Fill while held: hold = 1, push 16 pairs (a = i, b = 2i). Required: count reaches 16, in_ready = 0, a 17th push is ignored. Release hold: 16 consecutive issue cycles with op_a = 0..15 and op_b = 0..30 in order, then result_valid high for exactly 16 cycles.
3. Streaming: in_valid = 1 for 800 random pairs with hold = 0. Required: count never exceeds 1, issue = 1 every cycle after the first, and the golden adder's out on result_valid cycles equals a+b mod 2^26 for each pair in order.
4. Simultaneous push/pop at count = 5: push and pop in one cycle. Required: count stays 5, head advances, the new tail is issued after the 4 older entries.
5. Reset mid-operation: with 8 pairs buffered and 2 in flight, assert reset low for 1 edge. Required: count = 0, issue = 0, result_valid = 0 on every following cycle until a new pair is pushed.
6. Wrap-around: push and pop 40 pairs through a DEPTH = 4 instance with random hold. Required: order preserved across pointer wrap, count stays within 0..4, and no result_valid without a prior issue.
